game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter PADDLE_MIN, default 0: leftmost paddle x, in pixels.
REQ-002 Parameter PADDLE_MAX, default 576: rightmost paddle x, in pixels.
REQ-003 Parameter PADDLE_STEP, default 4: pixels moved per frame.
REQ-004 Parameter PADDLE_INIT, default 288: paddle x on serve.
REQ-005 Parameter LIVES_INIT, default 3: lives at game start, range 1..7.
REQ-006 Parameter LOST_FRAMES, default 60: frames spent in LOST.
REQ-007 clk  in  1  single system clock; all logic rising-edge.
REQ-008 nRst  in  1  reset, asynchronous assert, active-low.
REQ-009 en  in  1  design enable; when low, all state holds and pulse outputs are 0.
REQ-010 frame_tick  in  1  one-cycle pulse per video frame (start of vblank).
REQ-011 btn_left, btn_right, btn_select  in  1 each  raw buttons, active-high, pre-synchronised.
REQ-012 brick_hit  in  1  one-cycle pulse from the collision datapath.
REQ-013 ball_lost  in  1  one-cycle pulse when the ball passes the paddle.
REQ-014 bricks_cleared  in  1  level pulse when no bricks remain.
REQ-015 state  out  3  current game_state_t encoding.
REQ-016 paddle_x  out  10  paddle left edge.
REQ-017 lives  out  3  remaining lives.
REQ-018 score  out  8  bricks destroyed, saturating.
REQ-019 ball_launch  out  1  one-cycle pulse that releases the ball from the paddle.
REQ-020 level_reset  out  1  one-cycle pulse that restores the brick field and ball.

Function
REQ-021 Buttons are sampled only on frame_tick, which debounces them.
REQ-022 A press is sample=1 with the previous sample=0; the press is valid for that tick cycle only.
REQ-023 States: IDLE, SERVE, PLAY, LOST, OVER.
REQ-024 IDLE, on select press -> SERVE: lives=LIVES_INIT, score=0, paddle_x=PADDLE_INIT, level_reset pulses in the same cycle.
REQ-025 SERVE, on select press -> PLAY: ball_launch pulses in the same cycle.
REQ-026 PLAY, on ball_lost -> LOST: lives decrements, stopping at 0.
REQ-027 PLAY, on bricks_cleared with no ball_lost -> SERVE: level_reset pulses, score and lives are kept.
REQ-028 If ball_lost and bricks_cleared arrive in the same cycle, ball_lost wins.
REQ-029 LOST: a frame counter counts LOST_FRAMES ticks; it is cleared on entry.
REQ-030 LOST, at the end of the count -> OVER if lives==0, else -> SERVE with paddle_x=PADDLE_INIT.
REQ-031 OVER, on select press -> IDLE; score and lives are held until that point for display.
REQ-032 Paddle moves only in SERVE and PLAY, only on frame_tick, and only when exactly one of left/right is held.
REQ-033 Paddle motion is held level, not edge-triggered; left and right together means no motion.
REQ-034 Paddle steps saturate: left clamps at PADDLE_MIN, right clamps at PADDLE_MAX; paddle_x never wraps.
REQ-035 brick_hit increments score only in PLAY; score saturates at 255.
REQ-036 brick_hit in the same cycle as ball_lost still increments score.
REQ-037 brick_hit and ball_lost are ignored outside PLAY.
REQ-038 Every transition takes effect on the cycle after the triggering input, and state is registered.
REQ-039 ball_launch and level_reset are registered, last exactly one cycle, and are never asserted together.

Reset
REQ-040 On nRst low: state=IDLE, paddle_x=PADDLE_INIT, lives=0, score=0, pulses=0, button history=0, frame counter=0.
REQ-041 Reset mid-game abandons the game immediately; no level_reset pulse is emitted until the next select press.

Structure
REQ-042 A shared package breakout_pkg holds game_state_t and the width constants PADDLE_W=10, SCORE_W=8, LIVES_W=3.
REQ-043 Sub-module btn_edge, one instance per button, provides frame-sampled press detection and a held level.

Verification
REQ-044 Reset, then select held for 2 ticks -> state SERVE, one level_reset pulse, lives=3, score=0, paddle_x=288.
REQ-045 SERVE with right held for 80 ticks -> paddle_x=576, saturated; then left held for 200 ticks -> paddle_x=0; both held -> no change.
REQ-046 PLAY with 300 brick_hit pulses -> score=255; brick_hit in the same cycle as ball_lost -> score increments and state goes to LOST.
REQ-047 Lives=1 with ball_lost -> LOST, lives=0; after 60 ticks -> OVER; select press -> IDLE.
REQ-048 ball_lost and bricks_cleared in the same cycle -> LOST with no level_reset; en low for 100 ticks in PLAY -> all outputs frozen.

Source files
------------

// File: rtl/breakout_pkg.sv
// ============================================================================
// breakout_pkg : shared game-state encoding and datapath widths
// Revision     : 1.0
// ============================================================================
`default_nettype none

package breakout_pkg;

    localparam int PADDLE_W = 10;
    localparam int SCORE_W  = 8;
    localparam int LIVES_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_LOST  = 3'd3,
        ST_OVER  = 3'd4
    } game_state_t;

endpackage

`default_nettype wire

// File: rtl/btn_edge.sv
// ============================================================================
// btn_edge : frame-sampled press detector and held level for one button
// Revision : 1.0
// ============================================================================
`default_nettype none

module btn_edge (
    input  logic clk,
    input  logic nRst,
    input  logic en,
    input  logic tick,
    input  logic btn,
    output logic press,
    output logic held
);

    logic prev;

    // Sampling only on the frame tick gives a 16 ms debounce window.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            prev <= 1'b0;
        end else if (en && tick) begin
            prev <= btn;
        end
    end

    assign press = en && tick && btn && !prev;
    assign held  = btn;

endmodule

`default_nettype wire

// File: rtl/game_ctrl.sv
// ============================================================================
// game_ctrl : breakout game sequencer (state, paddle, lives, score, pulses)
// Revision  : 1.0
// ============================================================================
`default_nettype none

module game_ctrl
    import breakout_pkg::*;
#(
    parameter int PADDLE_MIN  = 0,
    parameter int PADDLE_MAX  = 576,
    parameter int PADDLE_STEP = 4,
    parameter int PADDLE_INIT = 288,
    parameter int LIVES_INIT  = 3,
    parameter int LOST_FRAMES = 60
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic                en,
    input  logic                frame_tick,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                btn_select,
    input  logic                brick_hit,
    input  logic                ball_lost,
    input  logic                bricks_cleared,
    output logic [2:0]          state,
    output logic [PADDLE_W-1:0] paddle_x,
    output logic [LIVES_W-1:0]  lives,
    output logic [SCORE_W-1:0]  score,
    output logic                ball_launch,
    output logic                level_reset
);

    localparam int PW1   = PADDLE_W + 1;
    localparam int CNT_W = (LOST_FRAMES > 1) ? $clog2(LOST_FRAMES) : 1;

    game_state_t         cur_state, nxt_state;
    logic [PADDLE_W-1:0] nxt_paddle;
    logic [LIVES_W-1:0]  nxt_lives;
    logic [SCORE_W-1:0]  nxt_score;
    logic [CNT_W-1:0]    lost_cnt, nxt_cnt;
    logic                nxt_launch, nxt_lreset;
    logic [PW1-1:0]      pad_up;

    logic left_press, left_held, right_press, right_held, sel_press, sel_held;
    logic unused_ok;

    btn_edge u_btn_left (
        .clk(clk), .nRst(nRst), .en(en), .tick(frame_tick),
        .btn(btn_left), .press(left_press), .held(left_held)
    );
    btn_edge u_btn_right (
        .clk(clk), .nRst(nRst), .en(en), .tick(frame_tick),
        .btn(btn_right), .press(right_press), .held(right_held)
    );
    btn_edge u_btn_select (
        .clk(clk), .nRst(nRst), .en(en), .tick(frame_tick),
        .btn(btn_select), .press(sel_press), .held(sel_held)
    );

    // Paddle uses levels, select uses edges; the remaining outputs are spare.
    assign unused_ok = &{1'b0, left_press, right_press, sel_held};

    assign state = cur_state;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cur_state   <= ST_IDLE;
            paddle_x    <= PADDLE_W'(PADDLE_INIT);
            lives       <= '0;
            score       <= '0;
            lost_cnt    <= '0;
            ball_launch <= 1'b0;
            level_reset <= 1'b0;
        end else begin
            cur_state   <= nxt_state;
            paddle_x    <= nxt_paddle;
            lives       <= nxt_lives;
            score       <= nxt_score;
            lost_cnt    <= nxt_cnt;
            ball_launch <= nxt_launch;
            level_reset <= nxt_lreset;
        end
    end

    always_comb begin
        nxt_state  = cur_state;
        nxt_paddle = paddle_x;
        nxt_lives  = lives;
        nxt_score  = score;
        nxt_cnt    = lost_cnt;
        nxt_launch = 1'b0;
        nxt_lreset = 1'b0;
        pad_up     = {1'b0, paddle_x} + PW1'(PADDLE_STEP);

        if (en) begin
            if ((cur_state == ST_SERVE || cur_state == ST_PLAY) && frame_tick) begin
                if (left_held && !right_held) begin
                    nxt_paddle = ({1'b0, paddle_x} < PW1'(PADDLE_MIN + PADDLE_STEP))
                               ? PADDLE_W'(PADDLE_MIN) : paddle_x - PADDLE_W'(PADDLE_STEP);
                end else if (right_held && !left_held) begin
                    nxt_paddle = (pad_up > PW1'(PADDLE_MAX))
                               ? PADDLE_W'(PADDLE_MAX) : pad_up[PADDLE_W-1:0];
                end
            end

            case (cur_state)
                ST_IDLE: begin
                    if (sel_press) begin
                        nxt_state  = ST_SERVE;
                        nxt_lives  = LIVES_W'(LIVES_INIT);
                        nxt_score  = '0;
                        nxt_paddle = PADDLE_W'(PADDLE_INIT);
                        nxt_lreset = 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (sel_press) begin
                        nxt_state  = ST_PLAY;
                        nxt_launch = 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (brick_hit && score != '1) begin
                        nxt_score = score + 1'b1;
                    end
                    // A lost ball outranks a cleared field arriving together.
                    if (ball_lost) begin
                        nxt_state = ST_LOST;
                        nxt_lives = (lives != '0) ? lives - 1'b1 : lives;
                        nxt_cnt   = '0;
                    end else if (bricks_cleared) begin
                        nxt_state  = ST_SERVE;
                        nxt_lreset = 1'b1;
                    end
                end
                ST_LOST: begin
                    if (frame_tick) begin
                        if (lost_cnt == CNT_W'(LOST_FRAMES - 1)) begin
                            if (lives == '0) begin
                                nxt_state = ST_OVER;
                            end else begin
                                nxt_state  = ST_SERVE;
                                nxt_paddle = PADDLE_W'(PADDLE_INIT);
                            end
                        end else begin
                            nxt_cnt = lost_cnt + 1'b1;
                        end
                    end
                end
                ST_OVER: begin
                    if (sel_press) begin
                        nxt_state = ST_IDLE;
                    end
                end
                default: nxt_state = ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_game_ctrl.sv
// ============================================================================
// tb_game_ctrl : vector table, directed game sequences and random run
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_game_ctrl;
    import breakout_pkg::*;

    localparam int P_MIN  = 0;
    localparam int P_MAX  = 576;
    localparam int P_STEP = 4;
    localparam int P_INIT = 288;
    localparam int L_INIT = 3;
    localparam int L_FR   = 60;

    localparam int S_IDLE  = int'(ST_IDLE);
    localparam int S_SERVE = int'(ST_SERVE);
    localparam int S_PLAY  = int'(ST_PLAY);
    localparam int S_LOST  = int'(ST_LOST);
    localparam int S_OVER  = int'(ST_OVER);

    logic clk, nRst, en, frame_tick, btn_left, btn_right, btn_select;
    logic brick_hit, ball_lost, bricks_cleared;
    logic [2:0]          state;
    logic [PADDLE_W-1:0] paddle_x;
    logic [LIVES_W-1:0]  lives;
    logic [SCORE_W-1:0]  score;
    logic                ball_launch, level_reset;

    game_ctrl #(
        .PADDLE_MIN(P_MIN), .PADDLE_MAX(P_MAX), .PADDLE_STEP(P_STEP),
        .PADDLE_INIT(P_INIT), .LIVES_INIT(L_INIT), .LOST_FRAMES(L_FR)
    ) dut (
        .clk(clk), .nRst(nRst), .en(en), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_select(btn_select),
        .brick_hit(brick_hit), .ball_lost(ball_lost), .bricks_cleared(bricks_cleared),
        .state(state), .paddle_x(paddle_x), .lives(lives), .score(score),
        .ball_launch(ball_launch), .level_reset(level_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int lr_seen  = 0;

    // Reference game model kept as plain integers.
    int ms, mp, ml, msc, mcnt;
    bit mprev, mbl, mlr;

    typedef struct {
        bit en, tk, l, r, s, hit, lost, clr;
        int st, pad, lv, sc;
        bit bl, lr;
    } vec_t;
    vec_t tbl[14];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("state", int'(state), ms);
        chk("paddle_x", int'(paddle_x), mp);
        chk("lives", int'(lives), ml);
        chk("score", int'(score), msc);
        chk("ball_launch", int'(ball_launch), int'(mbl));
        chk("level_reset", int'(level_reset), int'(mlr));
        chk("pulse_excl", int'(ball_launch & level_reset), 0);
    endtask

    task automatic clear_inputs();
        en = 1'b1; frame_tick = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        btn_select = 1'b0; brick_hit = 1'b0; ball_lost = 1'b0; bricks_cleared = 1'b0;
    endtask

    // One clock: predict from current inputs, advance, compare.
    task automatic cycle();
        int ns, np, nl, nsc, nc;
        bit npv, nb, nr, press;
        ns = ms; np = mp; nl = ml; nsc = msc; nc = mcnt; npv = mprev; nb = 0; nr = 0;
        if (en) begin
            press = frame_tick && btn_select && !mprev;
            if (frame_tick) npv = btn_select;
            if ((ms == S_SERVE || ms == S_PLAY) && frame_tick && (btn_left != btn_right))
                np = btn_left ? ((mp - P_STEP < P_MIN) ? P_MIN : mp - P_STEP)
                              : ((mp + P_STEP > P_MAX) ? P_MAX : mp + P_STEP);
            if (ms == S_IDLE && press) begin
                ns = S_SERVE; nl = L_INIT; nsc = 0; np = P_INIT; nr = 1;
            end else if (ms == S_SERVE && press) begin
                ns = S_PLAY; nb = 1;
            end else if (ms == S_PLAY) begin
                if (brick_hit) nsc = (msc + 1 > 255) ? 255 : msc + 1;
                if (ball_lost) begin
                    ns = S_LOST; nl = (ml > 0) ? ml - 1 : 0; nc = 0;
                end else if (bricks_cleared) begin
                    ns = S_SERVE; nr = 1;
                end
            end else if (ms == S_LOST && frame_tick) begin
                nc = mcnt + 1;
                if (nc == L_FR) begin
                    ns = (ml == 0) ? S_OVER : S_SERVE;
                    if (ml != 0) np = P_INIT;
                end
            end else if (ms == S_OVER && press) begin
                ns = S_IDLE;
            end
        end
        @(posedge clk);
        #1;
        ms = ns; mp = np; ml = nl; msc = nsc; mcnt = nc; mprev = npv; mbl = nb; mlr = nr;
        if (level_reset) lr_seen++;
        chk_model();
    endtask

    task automatic tick_cycle();
        frame_tick = 1'b1; cycle();
        frame_tick = 1'b0; cycle();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_cycle();
    endtask

    task automatic press_sel();
        btn_select = 1'b1; tick_cycle();
        btn_select = 1'b0; tick_cycle();
    endtask

    task automatic do_reset();
        clear_inputs();
        nRst = 1'b0;
        #2;
        ms = S_IDLE; mp = P_INIT; ml = 0; msc = 0; mcnt = 0; mprev = 0; mbl = 0; mlr = 0;
        chk_model();
        @(posedge clk);
        #1;
        nRst = 1'b1;
    endtask

    function automatic vec_t mk(bit en_i, bit tk, bit l, bit r, bit s, bit hit, bit lost,
                                bit clr, int st, int pad, int lv, int sc, bit bl, bit lr);
        vec_t v;
        v.en = en_i; v.tk = tk; v.l = l; v.r = r; v.s = s; v.hit = hit; v.lost = lost;
        v.clr = clr; v.st = st; v.pad = pad; v.lv = lv; v.sc = sc; v.bl = bl; v.lr = lr;
        return v;
    endfunction

    initial begin
        //           en tk l r s h lo cl  state    pad  lv sc bl lr
        tbl[0]  = mk(1, 1, 0,0,1,0,0,0, S_SERVE, 288, 3, 0, 0, 1);
        tbl[1]  = mk(1, 1, 0,0,1,0,0,0, S_SERVE, 288, 3, 0, 0, 0);
        tbl[2]  = mk(1, 1, 0,1,0,0,0,0, S_SERVE, 292, 3, 0, 0, 0);
        tbl[3]  = mk(1, 0, 0,1,0,0,0,0, S_SERVE, 292, 3, 0, 0, 0);
        tbl[4]  = mk(1, 1, 1,1,0,0,0,0, S_SERVE, 292, 3, 0, 0, 0);
        tbl[5]  = mk(1, 1, 1,0,0,0,0,0, S_SERVE, 288, 3, 0, 0, 0);
        tbl[6]  = mk(1, 0, 0,0,0,1,0,0, S_SERVE, 288, 3, 0, 0, 0);
        tbl[7]  = mk(1, 0, 0,0,0,0,1,0, S_SERVE, 288, 3, 0, 0, 0);
        tbl[8]  = mk(1, 1, 0,0,1,0,0,0, S_PLAY,  288, 3, 0, 1, 0);
        tbl[9]  = mk(1, 0, 0,0,0,1,0,0, S_PLAY,  288, 3, 1, 0, 0);
        tbl[10] = mk(0, 1, 0,1,1,1,1,0, S_PLAY,  288, 3, 1, 0, 0);
        tbl[11] = mk(1, 0, 0,0,0,1,1,1, S_LOST,  288, 2, 2, 0, 0);
        tbl[12] = mk(1, 0, 0,0,0,1,0,0, S_LOST,  288, 2, 2, 0, 0);
        tbl[13] = mk(1, 1, 1,0,0,0,0,0, S_LOST,  288, 2, 2, 0, 0);

        nRst = 1'b1;
        clear_inputs();
        #3;
        do_reset();

        for (int i = 0; i < 14; i++) begin
            en = tbl[i].en; frame_tick = tbl[i].tk; btn_left = tbl[i].l; btn_right = tbl[i].r;
            btn_select = tbl[i].s; brick_hit = tbl[i].hit; ball_lost = tbl[i].lost;
            bricks_cleared = tbl[i].clr;
            cycle();
            chk($sformatf("vec%0d.state", i), int'(state), tbl[i].st);
            chk($sformatf("vec%0d.paddle", i), int'(paddle_x), tbl[i].pad);
            chk($sformatf("vec%0d.lives", i), int'(lives), tbl[i].lv);
            chk($sformatf("vec%0d.score", i), int'(score), tbl[i].sc);
            chk($sformatf("vec%0d.launch", i), int'(ball_launch), int'(tbl[i].bl));
            chk($sformatf("vec%0d.lreset", i), int'(level_reset), int'(tbl[i].lr));
        end

        // Start of game with select held over two frames.
        do_reset();
        lr_seen = 0;
        btn_select = 1'b1;
        ticks(2);
        btn_select = 1'b0;
        chk("start.lr_pulses", lr_seen, 1);
        chk("start.state", int'(state), S_SERVE);
        chk("start.lives", int'(lives), 3);
        chk("start.score", int'(score), 0);
        chk("start.paddle", int'(paddle_x), 288);

        // Paddle saturation in both directions and the both-held dead zone.
        btn_right = 1'b1; ticks(80);
        chk("paddle.max", int'(paddle_x), 576);
        btn_right = 1'b0; btn_left = 1'b1; ticks(200);
        chk("paddle.min", int'(paddle_x), 0);
        btn_right = 1'b1; ticks(5);
        chk("paddle.both", int'(paddle_x), 0);
        btn_left = 1'b0; btn_right = 1'b0;

        // Score saturation, then a hit coinciding with a lost ball.
        press_sel();
        chk("play.state", int'(state), S_PLAY);
        for (int i = 0; i < 300; i++) begin
            brick_hit = 1'b1; cycle();
            brick_hit = 1'b0; cycle();
        end
        chk("score.sat", int'(score), 255);
        brick_hit = 1'b1; ball_lost = 1'b1; cycle();
        brick_hit = 1'b0; ball_lost = 1'b0;
        chk("hitlost.state", int'(state), S_LOST);
        chk("hitlost.lives", int'(lives), 2);

        // Burn the remaining lives down to game over.
        ticks(L_FR - 1);
        chk("lost.hold", int'(state), S_LOST);
        ticks(1);
        chk("lost.serve", int'(state), S_SERVE);
        chk("lost.paddle", int'(paddle_x), 288);
        for (int k = 0; k < 2; k++) begin
            press_sel();
            ball_lost = 1'b1; cycle(); ball_lost = 1'b0;
            ticks(L_FR - 1);
            chk("lost.wait", int'(state), S_LOST);
            ticks(1);
        end
        chk("over.state", int'(state), S_OVER);
        chk("over.lives", int'(lives), 0);
        chk("over.score", int'(score), 255);
        press_sel();
        chk("over.idle", int'(state), S_IDLE);

        // Enable low freezes everything; then a cleared field re-serves.
        press_sel();
        press_sel();
        en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            btn_left = 1'($urandom); btn_right = 1'($urandom); btn_select = 1'($urandom);
            brick_hit = 1'($urandom); ball_lost = 1'($urandom);
            bricks_cleared = 1'($urandom);
            tick_cycle();
        end
        clear_inputs();
        chk("en_low.state", int'(state), S_PLAY);
        chk("en_low.score", int'(score), 0);
        bricks_cleared = 1'b1; cycle(); bricks_cleared = 1'b0;
        chk("cleared.state", int'(state), S_SERVE);
        chk("cleared.lreset", int'(level_reset), 1);

        // Mid-game reset abandons the game with no stray level_reset.
        press_sel();
        do_reset();
        chk("midreset.state", int'(state), S_IDLE);
        lr_seen = 0;
        ticks(10);
        chk("midreset.lr", lr_seen, 0);

        // Random play against the model.
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 2999) == 0) begin
                do_reset();
            end else begin
                en             = ($urandom_range(0, 9) != 0);
                frame_tick     = ($urandom_range(0, 3) == 0);
                btn_left       = 1'($urandom);
                btn_right      = 1'($urandom);
                btn_select     = ($urandom_range(0, 4) == 0);
                brick_hit      = ($urandom_range(0, 2) == 0);
                ball_lost      = ($urandom_range(0, 19) == 0);
                bricks_cleared = ($urandom_range(0, 19) == 0);
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
